// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word-aligned RAM accesses,
// big-endian sub-word extraction and read-modify-write merging for sb/sh.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_write,
  output logic              ram_write_en,
  output logic              ram_read_en,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_write;
  logic [DATA_W-1:0] r_merged;
  logic [DATA_W-1:0] r_rdata;
  logic              r_error;
  logic              w_err;
  logic              w_accept;

  // Lane 0 is the most significant byte (big-endian).
  function automatic logic [DATA_W-1:0] f_load_ext(input logic [DATA_W-1:0] word,
                                                   input logic [1:0] off,
                                                   input logic [1:0] size,
                                                   input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] word,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [1:0] off,
                                                input logic [1:0] size);
    logic [DATA_W-1:0] m;
    m = word;
    if (size == 2'b00) begin
      case (off)
        2'd0:    m[31:24] = wdata[7:0];
        2'd1:    m[23:16] = wdata[7:0];
        2'd2:    m[15:8]  = wdata[7:0];
        default: m[7:0]   = wdata[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) m[15:0]  = wdata[15:0];
      else        m[31:16] = wdata[15:0];
    end else begin
      m = wdata;
    end
    return m;
  endfunction

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_err    = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    ram_read_en    = 1'b0;
    ram_write_en   = 1'b0;
    ram_address    = '0;
    ram_data_write = '0;
    case (r_state)
      S_INIT: w_next = S_IDLE;
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                                w_next = S_RESP;
          else if (req_write && req_size == 2'b10)  w_next = S_WR;
          else                                      w_next = S_RD;
        end
      end
      S_RD: begin
        ram_read_en = 1'b1;
        ram_address = {r_addr[ADDR_W-1:2], 2'b00};
        w_next      = r_write ? S_WR : S_RESP;
      end
      S_WR: begin
        ram_write_en   = 1'b1;
        ram_address    = {r_addr[ADDR_W-1:2], 2'b00};
        ram_data_write = r_merged;
        w_next         = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  // Response fields only change on the way into RESP, so they hold between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      r_merged   <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_write    <= req_write;
        r_merged   <= req_wdata;
        if (w_err) begin
          r_rdata <= '0;
          r_error <= 1'b1;
        end
      end
      if (r_state == S_RD) begin
        if (r_write) begin
          r_merged <= f_merge(ram_data_out, r_wdata, r_addr[1:0], r_size);
        end else begin
          r_rdata <= f_load_ext(ram_data_out, r_addr[1:0], r_size, r_unsigned);
          r_error <= 1'b0;
        end
      end
      if (r_state == S_WR) begin
        r_rdata <= '0;
        r_error <= 1'b0;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Accepts one load or store per request from the CPU MEM stage, issues word-aligned accesses to the word-wide data `RAM`, and merges byte/halfword stores by read-modify-write. Performs load sign/zero extension, and flags misaligned or illegal requests without touching memory. Sits between the pipeline MEM stage, which stalls on `req_ready`, and the `RAM` block.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; fixed at 32 (4 byte lanes).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request this cycle.
- `req_write` input 1: 1 means store, 0 means load.
- `req_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` input 1: zero-extend loads (lbu/lhu); ignored for word and for stores.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_error` output 1: valid with `resp_valid`; misaligned or illegal size.
- `ram_address` output 32: word-aligned byte address, low 2 bits always 0.
- `ram_data_write` output 32: word to write.
- `ram_write_en` output 1: RAM write strobe; RAM writes on the rising edge.
- `ram_read_en` output 1: RAM read enable; the RAM read path is combinational.
- `ram_data_out` input 32: RAM read data.

## Operation
- States: INIT, IDLE, RD, WR, RESP.
- Reset: state INIT. All outputs 0; the internal latches for `addr`, `wdata`, `size`, `unsigned` and the merged word are cleared.
- INIT:
  - Lasts exactly one cycle after reset release, then goes to IDLE.
  - `req_ready` stays 0 so the RAM's first-cycle preload edge is never used for a write.
- IDLE:
  - `req_ready` is 1.
  - On `req_valid`, latch all `req_*` fields and check legality.
  - Error if `size==11`, if half with `addr[0]!=0`, or if word with `addr[1:0]!=0`. On error go to RESP with error set; no RAM strobe.
  - Legal load, or store with size byte or half, goes to RD. Store word goes to WR with `ram_data_write = wdata`.
- RD:
  - Drives `ram_read_en=1` and `ram_address={addr[31:2],2'b00}`.
  - Samples `ram_data_out` at the end of the cycle.
  - Load: extract, extend, register into `resp_rdata`, then go to RESP.
  - Store: merge the new lane into the sampled word, then go to WR.
- Lane mapping is big-endian (MIPS):
  - Byte offset 0 is [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0].
  - Half offset 0 is [31:16], offset 2 is [15:0].
  - Load sign-extends from the lane MSB unless `unsigned`.
- WR: drives `ram_write_en=1`, the aligned address and the merged/full word for one cycle, then goes to RESP.
- RESP:
  - `resp_valid=1` for one cycle; `resp_rdata` and `resp_error` are valid.
  - Returns to IDLE; `req_ready` goes 1 the following cycle.
- Outside their own state, `ram_read_en` and `ram_write_en` are 0.
- Only one request is ever in flight; `req_valid` while `req_ready=0` is ignored. The MEM stage holds the request until accepted.
- Reset mid-operation aborts immediately and strobes drop asynchronously. A WR cycle cut by reset may or may not have updated RAM; there is no other partial effect.

## Timing
- Acceptance edge T0 (IDLE with `req_valid`).
- Load: RD in cycle T0+1; `resp_valid` in cycle T0+2. Latency is 2.
- Store word: WR in T0+1; `resp_valid` in T0+2. RAM is updated at the end of T0+1.
- Store byte/half: RD in T0+1, WR in T0+2, `resp_valid` in T0+3. Latency is 3.
- Error: `resp_valid` in T0+1 with `resp_error=1`.
- Minimum request spacing is latency+1 cycles, because IDLE follows RESP.
- `resp_rdata` holds its value until the next RESP; `resp_valid` is the only qualifier.

## Test plan
- Reset low, then release. `req_ready` stays 0 for exactly one cycle, then goes 1. `ram_*` strobes stay 0 throughout.
- Store word 0x12345678 at 0x8, then load word at 0x8.
  - Expect `ram_write_en` for one cycle with address 0x8.
  - The load returns 0x12345678 two cycles after acceptance.
- With RAM word 0 = 0x0000F1E0:
  - lb at 0x3 returns 0xFFFFFFE0.
  - lbu at 0x3 returns 0x000000E0.
  - lh at 0x2 returns 0xFFFFF1E0.
  - lhu at 0x2 returns 0x0000F1E0.
- sb 0xAB at 0x5 over word 1 = 0x0000001E. Expect RD then WR with data 0x00AB001E; `resp_valid` three cycles after acceptance.
- lw at 0x6, sh at 0x1, and size 11: each gives `resp_error=1` one cycle after acceptance, `resp_rdata=0`, and no `ram_read_en` or `ram_write_en`.
- Assert reset during the RD of an sb. The unit returns to INIT, the RAM word is unchanged, and the next lw returns the original value.
